// File: rtl/fft_mul_arb_pkg.sv
// fft_mul_arb_pkg: shared constants, tag type and round-robin helper for the
// FFT multiplier arbiter.
//   A_W/B_W/P_W : operand and product widths (signed x unsigned -> signed)
//   MUL_LAT     : issue-to-response latency of the multiplier core
//   tag_t       : requester index carried alongside each operation
//   rr_pick     : one-hot round-robin grant over up to 8 requesters
package fft_mul_arb_pkg;

  localparam int unsigned A_W     = 22;
  localparam int unsigned B_W     = 15;
  localparam int unsigned P_W     = 37;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned TAG_W_DEF = 3;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= 8).
  function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [7:0]  grant;
    logic        found;
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < n) begin
        idx = (32'(ptr) + k) % n;
        if (!found && valid[idx[2:0]]) begin
          grant[idx[2:0]] = 1'b1;
          found           = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/fft_mul_core.sv
// fft_mul_core: two-stage signed x unsigned multiplier intended to map onto a
// single DSP slice. Inputs are registered, then the product is registered.
// Data registers carry no reset so they can be absorbed into the DSP.
//   clk : clock
//   ce  : clock enable; low freezes both stages
//   a   : signed multiplicand (A_W)
//   b   : unsigned multiplier (B_W)
//   p   : signed product (P_W), exact
module fft_mul_core
  import fft_mul_arb_pkg::*;
(
  input  logic           clk,
  input  logic           ce,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  logic signed [A_W-1:0] a_q;
  logic        [B_W-1:0] b_q;
  logic signed [P_W-1:0] p_q;

  always_ff @(posedge clk) begin
    if (ce) begin
      a_q <= a;
      b_q <= b;
      // b is zero-extended so the multiply stays signed and exact
      p_q <= P_W'(a_q) * P_W'($signed({1'b0, b_q}));
    end
  end

  assign p = p_q;

endmodule

// File: rtl/fft_mul_arbiter.sv
// fft_mul_arbiter: shares one pipelined multiplier core between NREQ
// requesters. Round-robin issue arbitration, a tag/valid shadow pipeline
// alongside the core, and a response demux. Response backpressure stalls the
// whole pipeline through the core clock enable.
// Build option FFT_MUL_ARB_PRIO0_EN: requester 0 gets strict priority and the
// round-robin pointer rotates over requesters 1..NREQ-1 only.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester issue handshake
//   req_a, req_b        : packed operands, requester i at [W*i +: W]
//   rsp_valid/rsp_ready : one-hot response handshake
//   rsp_p, rsp_tag      : shared product bus and owning requester index
//   busy                : any operation in flight
module fft_mul_arbiter
  import fft_mul_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAG_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [P_W-1:0]      rsp_p,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                busy
);

`ifdef FFT_MUL_ARB_PRIO0_EN
  localparam logic [2:0] RR_RST = 3'd1;
`else
  localparam logic [2:0] RR_RST = 3'd0;
`endif

  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             s1_valid_q, s2_valid_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;

  logic [7:0]       valid8;
  logic [NREQ-1:0]  grant;
  logic             any_grant;
  logic [2:0]       gnt_idx;
  logic [TAG_W-1:0] gnt_tag;
  logic [A_W-1:0]   issue_a;
  logic [B_W-1:0]   issue_b;
  logic             s2_ready;
  logic             ce;

  always_comb begin
    valid8             = '0;
    valid8[NREQ-1:0]   = req_valid;
`ifdef FFT_MUL_ARB_PRIO0_EN
    if (req_valid[0]) grant = NREQ'(1);
    else              grant = NREQ'(rr_pick(valid8 & 8'hFE, rr_ptr_q, NREQ));
`else
    grant = NREQ'(rr_pick(valid8, rr_ptr_q, NREQ));
`endif
    any_grant = |grant;

    gnt_idx = '0;
    gnt_tag = '0;
    issue_a = '0;
    issue_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx = 3'(i);
        gnt_tag = TAG_W'(i);
        issue_a = req_a[A_W*i +: A_W];
        issue_b = req_b[B_W*i +: B_W];
      end
    end

    // Compare-based demux keeps the tag-indexed lookup in range for any TAG_W
    s2_ready  = 1'b0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (s2_tag_q == TAG_W'(i)) begin
        s2_ready     = rsp_ready[i];
        rsp_valid[i] = s2_valid_q;
      end
    end

    ce        = !(s2_valid_q && !s2_ready);
    req_ready = ce ? grant : '0;

    rr_ptr_d = rr_ptr_q;
    if (ce && any_grant) begin
`ifdef FFT_MUL_ARB_PRIO0_EN
      // Priority grants to requester 0 leave the rotation among 1..NREQ-1 alone
      if (gnt_idx != 3'd0)
        rr_ptr_d = (gnt_idx == 3'(NREQ-1)) ? 3'd1 : gnt_idx + 3'd1;
`else
      rr_ptr_d = (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= RR_RST;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
    end else if (ce) begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= any_grant;
      s1_tag_q   <= gnt_tag;
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  fft_mul_core u_core (
    .clk (clk),
    .ce  (ce),
    .a   (issue_a),
    .b   (issue_b),
    .p   (rsp_p)
  );

  assign rsp_tag = s2_tag_q;
  assign busy    = s1_valid_q | s2_valid_q;

endmodule
